// File: rtl/mem_copy_ctrl_if.sv
// Signal bundle between mem_copy_ctrl (master) and the host plus ROM/RAM ports (slave).
interface mem_copy_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          locked;
   logic          start;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_q;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_wren;
   logic [DW-1:0] ram_q;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] err_addr;

   modport master (
      input  locked, start, rom_q, ram_q,
      output rom_addr, ram_addr, ram_data, ram_wren, busy, done, err, err_addr
   );

   modport slave (
      output locked, start, rom_q, ram_q,
      input  rom_addr, ram_addr, ram_data, ram_wren, busy, done, err, err_addr
   );
endinterface

// File: rtl/mem_copy_ctrl.sv
// Copies a 2^AW-word ROM into RAM through an RD_LAT-deep address/valid delay line.
// Define MEM_COPY_VERIFY_EN to compile in the RAM readback/compare phase.
module mem_copy_ctrl #(
   parameter int RD_LAT = 2,
   parameter int AW     = 8,
   parameter int DW     = 8
) (
   input logic             clk,
   input logic             rst,
   mem_copy_ctrl_if.master bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_COPY   = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
`ifdef MEM_COPY_VERIFY_EN
   localparam logic [2:0] S_VERIFY = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;
`endif
   localparam logic [2:0] S_FIN    = 3'd5;
   localparam logic [AW-1:0]     ADDR_LAST = {AW{1'b1}};
   // Delay line holds only its final entry: last read of a phase is emerging now.
   localparam logic [RD_LAT-1:0] DL_LAST   = RD_LAT'(1) << (RD_LAT - 1);

   logic [2:0]        state_r;
   logic [AW-1:0]     rom_addr_r;
   logic [AW-1:0]     dl_addr_r [RD_LAT];
   logic [RD_LAT-1:0] dl_valid_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
   logic              issue_s;
   logic              abort_s;
   logic              dl_out_s;
   logic              last_only_s;
   logic              wren_s;
`ifdef MEM_COPY_VERIFY_EN
   logic              vphase_r;
   logic [AW-1:0]     err_addr_r;
   logic              mismatch_s;
`else
   logic              unused_ram_q_s;
`endif

   assign dl_out_s    = dl_valid_r[RD_LAT-1];
   assign last_only_s = (dl_valid_r == DL_LAST);
   assign abort_s     = busy_r & ~bus.locked;

`ifdef MEM_COPY_VERIFY_EN
   assign issue_s      = (state_r == S_COPY) || (state_r == S_VERIFY);
   assign wren_s       = dl_out_s & ~vphase_r;
   assign mismatch_s   = dl_out_s & vphase_r & (bus.rom_q != bus.ram_q);
   assign bus.ram_addr = vphase_r ? rom_addr_r
                                  : (wren_s ? dl_addr_r[RD_LAT-1] : {AW{1'b0}});
   assign bus.err_addr = err_addr_r;
`else
   assign issue_s        = (state_r == S_COPY);
   assign wren_s         = dl_out_s;
   assign bus.ram_addr   = wren_s ? dl_addr_r[RD_LAT-1] : {AW{1'b0}};
   assign bus.err_addr   = {AW{1'b0}};
   assign unused_ram_q_s = ^bus.ram_q;
`endif

   assign bus.ram_wren = wren_s;
   assign bus.ram_data = wren_s ? bus.rom_q : {DW{1'b0}};
   assign bus.rom_addr = rom_addr_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.err      = err_r;

   // Address/valid delay line matching the memory read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst || abort_s) begin
         dl_valid_r <= {RD_LAT{1'b0}};
         for (int i = 0; i < RD_LAT; i++) dl_addr_r[i] <= {AW{1'b0}};
      end else begin
         dl_valid_r[0] <= issue_s;
         dl_addr_r[0]  <= rom_addr_r;
         for (int i = 1; i < RD_LAT; i++) begin
            dl_valid_r[i] <= dl_valid_r[i-1];
            dl_addr_r[i]  <= dl_addr_r[i-1];
         end
      end
   end

   // Run sequencing, status flags and the issue address counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_IDLE;
         rom_addr_r <= {AW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
`ifdef MEM_COPY_VERIFY_EN
         vphase_r   <= 1'b0;
         err_addr_r <= {AW{1'b0}};
`endif
      end else if (abort_s) begin
         state_r    <= S_IDLE;
         rom_addr_r <= {AW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b1;
         err_r      <= 1'b1;
`ifdef MEM_COPY_VERIFY_EN
         vphase_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            S_IDLE: begin
               if (bus.start && bus.locked) begin
                  state_r    <= S_COPY;
                  rom_addr_r <= {AW{1'b0}};
                  busy_r     <= 1'b1;
                  done_r     <= 1'b0;
                  err_r      <= 1'b0;
`ifdef MEM_COPY_VERIFY_EN
                  err_addr_r <= {AW{1'b0}};
`endif
               end
            end
            // Counter wraps to 0 on the terminal address, ready for readback.
            S_COPY: begin
               rom_addr_r <= rom_addr_r + AW'(1);
               if (rom_addr_r == ADDR_LAST) state_r <= S_DRAIN;
            end
            S_DRAIN: begin
               if (last_only_s) begin
`ifdef MEM_COPY_VERIFY_EN
                  state_r  <= S_VERIFY;
                  vphase_r <= 1'b1;
`else
                  state_r  <= S_FIN;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
`endif
               end
            end
`ifdef MEM_COPY_VERIFY_EN
            S_VERIFY: begin
               rom_addr_r <= rom_addr_r + AW'(1);
               if (rom_addr_r == ADDR_LAST) state_r <= S_FLUSH;
            end
            S_FLUSH: begin
               if (last_only_s) begin
                  state_r <= S_FIN;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
`endif
            S_FIN: begin
               state_r <= S_IDLE;
`ifdef MEM_COPY_VERIFY_EN
               vphase_r <= 1'b0;
`endif
            end
            default: state_r <= S_IDLE;
         endcase
`ifdef MEM_COPY_VERIFY_EN
         if (mismatch_s && !err_r) begin
            err_r      <= 1'b1;
            err_addr_r <= dl_addr_r[RD_LAT-1];
         end
`endif
      end
   end
endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Bench for mem_copy_ctrl: behavioural ROM/RAM with RD_LAT read latency and an arithmetic run model.
// Define MEM_COPY_VERIFY_EN to build with the readback phase and its corruption test.
module tb_mem_copy_ctrl;
   localparam int RD_LAT  = 2;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int DEPTH   = 1 << AW;
`ifdef MEM_COPY_VERIFY_EN
   localparam int RUN_LEN = 2 * (DEPTH + RD_LAT);
`else
   localparam int RUN_LEN = DEPTH + RD_LAT;
`endif
   localparam int MAX_CYC = 4 * DEPTH;

   logic clk = 1'b0;
   logic rst;
   logic corrupt_en;
   int   vectors     = 0;
   int   miscompares = 0;
   int   run_cyc;
   int   run_wr;
   int   run_busy;

   logic [DW-1:0] rom_mem  [DEPTH];
   logic [DW-1:0] ram_mem  [DEPTH];
   logic [AW-1:0] rom_pipe [RD_LAT];
   logic [AW-1:0] ram_pipe [RD_LAT];

   mem_copy_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   mem_copy_ctrl #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.rom_q = rom_mem[rom_pipe[RD_LAT-1]];
   assign bus.ram_q = ram_mem[ram_pipe[RD_LAT-1]];

   // Memories: registered read address pipeline, synchronous write
   always @(posedge clk) begin
      rom_pipe[0] <= bus.rom_addr;
      ram_pipe[0] <= bus.ram_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         rom_pipe[i] <= rom_pipe[i-1];
         ram_pipe[i] <= ram_pipe[i-1];
      end
      if (bus.ram_wren === 1'b1) begin
         if (corrupt_en && (bus.ram_addr == 8'h33 || bus.ram_addr == 8'h90))
            ram_mem[bus.ram_addr] <= ~bus.ram_data;
         else
            ram_mem[bus.ram_addr] <= bus.ram_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      run_cyc++;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},     32'(bus.busy),     32'd0);
      check({tag, "_done"},     32'(bus.done),     32'd0);
      check({tag, "_err"},      32'(bus.err),      32'd0);
      check({tag, "_ram_wren"}, 32'(bus.ram_wren), 32'd0);
      check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
      check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
      check({tag, "_ram_data"}, 32'(bus.ram_data), 32'd0);
      check({tag, "_err_addr"}, 32'(bus.err_addr), 32'd0);
   endtask

   task automatic fill_rom_random();
      for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'($urandom);
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(1, 5)) tick();
   endtask

   // Pulse start from a negedge; afterwards we sit in the first busy cycle.
   task automatic start_run();
      run_cyc  = 0;
      run_wr   = 0;
      run_busy = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("accept_busy",     32'(bus.busy),     32'd1);
      check("accept_done",     32'(bus.done),     32'd0);
      check("accept_err",      32'(bus.err),      32'd0);
      check("accept_err_addr", 32'(bus.err_addr), 32'd0);
   endtask

   // Follow the run while busy; write k must hit address k with ROM[k] at cycle k+1+RD_LAT.
   task automatic watch(input int stop_at);
      bit stop;
      stop = 1'b0;
      while (!stop && bus.busy === 1'b1 && run_cyc <= MAX_CYC) begin
         run_busy++;
         if (bus.ram_wren === 1'b1) begin
            check("wr_addr",  32'(bus.ram_addr), 32'(run_wr));
            check("wr_data",  32'(bus.ram_data), 32'(rom_mem[run_wr % DEPTH]));
            check("wr_cycle", 32'(run_cyc),      32'(run_wr + 1 + RD_LAT));
            if (run_wr == stop_at) stop = 1'b1;
            run_wr++;
         end
         if (!stop) tick();
      end
   endtask

   task automatic check_end(input int exp_wr, input int exp_busy, input logic exp_err);
      check("end_busy",    32'(bus.busy), 32'd0);
      check("busy_len",    32'(run_busy), 32'(exp_busy));
      check("write_count", 32'(run_wr),   32'(exp_wr));
      check("end_done",    32'(bus.done), 32'd1);
      check("end_err",     32'(bus.err),  32'(exp_err));
   endtask

   task automatic check_ram();
      for (int a = 0; a < DEPTH; a++)
         check("ram_word", 32'(ram_mem[a]), 32'(rom_mem[a]));
   endtask

   initial begin
      rst        = 1'b1;
      corrupt_en = 1'b0;
      bus.start  = 1'b0;
      bus.locked = 1'b1;
      run_cyc    = 0;
      for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'(a) ^ 8'h5A;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(bus.busy), 32'd0);

      // start while unlocked is ignored
      bus.locked = 1'b0;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      bus.locked = 1'b1;
      tick();
      check("nolock_busy", 32'(bus.busy), 32'd0);
      check("nolock_done", 32'(bus.done), 32'd0);

      // Plain copy of addr ^ 5A
      start_run();
      watch(-1);
      check_end(DEPTH, RUN_LEN, 1'b0);
      check("clean_err_addr", 32'(bus.err_addr), 32'd0);
      check_ram();
      repeat (3) tick();
      check("done_held", 32'(bus.done), 32'd1);

      // Second start at write 100 is ignored
      fill_rom_random();
      idle_gap();
      start_run();
      watch(100);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      watch(-1);
      check_end(DEPTH, RUN_LEN, 1'b0);
      check_ram();

      // Lock lost at write 40 aborts the run
      fill_rom_random();
      idle_gap();
      start_run();
      watch(40);
      bus.locked = 1'b0;
      tick();
      check_end(41, 41 + RD_LAT, 1'b1);
      check("abort_wren", 32'(bus.ram_wren), 32'd0);
      bus.locked = 1'b1;
      repeat (3) tick();
      check("abort_idle_wren", 32'(bus.ram_wren), 32'd0);
      check("abort_idle_busy", 32'(bus.busy),     32'd0);

      // Fresh run after the abort completes cleanly
      start_run();
      watch(-1);
      check_end(DEPTH, RUN_LEN, 1'b0);
      check_ram();

      // Reset pulse at write 128
      fill_rom_random();
      idle_gap();
      start_run();
      watch(128);
      rst = 1'b1;
      #1;
      check_zero("midrun_rst");
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("post_rst_wren", 32'(bus.ram_wren), 32'd0);
         check("post_rst_busy", 32'(bus.busy),     32'd0);
      end
      check("post_rst_done", 32'(bus.done), 32'd0);

`ifdef MEM_COPY_VERIFY_EN
      // Corrupted RAM writes at 33 and 90 are caught by readback; first one is reported
      fill_rom_random();
      corrupt_en = 1'b1;
      start_run();
      watch(-1);
      check_end(DEPTH, RUN_LEN, 1'b1);
      check("verify_err_addr", 32'(bus.err_addr), 32'h33);
      check("verify_done_cycle", 32'(run_cyc), 32'(RUN_LEN + 1));
      corrupt_en = 1'b0;
`else
      // Clean run straight after the reset
      fill_rom_random();
      start_run();
      watch(-1);
      check_end(DEPTH, RUN_LEN, 1'b0);
      check("final_err_addr", 32'(bus.err_addr), 32'd0);
      check_ram();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
